bus_pattern_checker: RTL
========================

Name: bus_pattern_checker

Overview:
Parametrised receive-side checker for the RPi parallel bus. It waits for a two-word sync header, then checks NUM_WORDS data words sampled on rising bus_clk edges against a selectable reference pattern, and counts mismatches. It then returns a three-word status report over the same bus when the master reads. The top level owns the inout pin; this block exposes separate in/out/oe signals.

Parameters:
DATA_W, 8, bus word width in bits (4..16)
NUM_WORDS, 256, data words checked per run (1..65535)
SYNC0, 8'hB8, first sync word (DATA_W bits)
SYNC1, 8'h8B, second sync word (DATA_W bits)
LFSR_TAPS, 8'hB8, Galois LFSR tap mask (DATA_W bits)
LFSR_SEED, 8'h01, LFSR start value; must be non-zero
CNT_W, 16, width of the error counter and the index registers

Ports:
clk_100mhz  in  1  system clock
reset  in  1  synchronous, active-high
bus_clk  in  1  async strobe from the RPi
bus_rnw  in  1  1 = master reads, 0 = master writes (async)
bus_data_in  in  DATA_W  bus pins, input path (async)
bus_data_out  out  DATA_W  bus drive value
bus_data_oe  out  1  1 = top drives bus_data_out onto the pins
mode  in  2  0 incr, 1 decr, 2 LFSR, 3 constant SYNC1; sampled at sync match
busy  out  1  high from the SYNC1 match until the report completes
pass  out  1  last run had zero errors; valid when done=1
done  out  1  pulses for 1 cycle when the report completes
err_count  out  CNT_W  saturating error count for the current or last run

Behaviour:
- Reset: state IDLE; bus_data_out=0, bus_data_oe=0, busy=0, pass=0, done=0, err_count=0. Reset mid-run aborts the run; nothing else is retained.
- Synchronisation: bus_clk, bus_rnw and bus_data_in each pass through a 2-flop synchroniser.
- Edge detect: a third flop on bus_clk gives a rising-edge pulse (clk_edge). All bus sampling uses clk_edge only, never level.
- IDLE: 1 cycle. Clears err_count, word index idx and first_err_idx (all-ones = none). Goes to SYNC_A.
- SYNC_A: on clk_edge with data==SYNC0, go to SYNC_B.
- SYNC_B: on the next clk_edge:
  - data==SYNC1: latch mode, load ref (incr 0, decr all-ones, LFSR LFSR_SEED, const SYNC1), set busy, go to RECV.
  - data==SYNC0: stay in SYNC_B.
  - anything else: go to SYNC_A.
- RECV: on each clk_edge with bus_rnw=0:
  - Compare data to ref.
  - On mismatch: err_count+1, saturating at 2^CNT_W-1. On the first mismatch, also latch first_err_idx=idx.
  - Advance ref: incr +1 mod 2^DATA_W; decr -1; LFSR: shift right, XOR LFSR_TAPS if the old LSB was 1; const unchanged.
  - idx+1. After word NUM_WORDS-1, go to REPORT.
  - clk_edge with bus_rnw=1 in RECV counts as a mismatch for that word.
- REPORT: drive the status words in order, one per read.
  - bus_data_oe follows the synced bus_rnw.
  - bus_data_out presents the current status word: 0 = {0..,pass_bit}, 1 = err_count[DATA_W-1:0], 2 = first_err_idx[DATA_W-1:0].
  - Advance to the next word on each falling edge of synced bus_clk while bus_rnw=1.
  - After word 2 is consumed: done=1 for 1 cycle, pass=(err_count==0), busy=0, go to IDLE to re-arm.
  - If bus_rnw returns to 0 before all 3 words are read, stay in REPORT holding the current word.
- pass holds its value until the next run's report completes.
- Latency: an error appears on err_count 1 clk after the clk_edge cycle (data compared 3 clks after the pin change).
- Bus clock ceiling: bus_clk high and low phases are each ≥3 clk_100mhz cycles. Faster strobes are unsupported.

Optional Feature:
- Macro: PATTERN_LFSR_EN.
- Defined: mode 2 selects the Galois LFSR as described.
- Undefined: no LFSR logic is built, LFSR_TAPS and LFSR_SEED are ignored, and mode 2 behaves exactly as mode 0 (increment).

Decomposition:
- Package bus_test_pkg holds:
  - state encoding localparams (ST_IDLE, ST_SYNC_A, ST_SYNC_B, ST_RECV, ST_REPORT)
  - mode codes (MODE_INC, MODE_DEC, MODE_LFSR, MODE_CONST)
  - the report word index constants
- Sub-module bus_sync_edge: 2-flop synchroniser on clk/rnw/data plus rise/fall pulses on clk. The same codebase's transmit-side blocks reuse it.

Test Plan:
1. Defaults, mode 0, send B8,8B,00..FF in order, then read 3 words -> reads return 01,00,FF; pass=1; done pulses once; err_count=0.
2. Mode 0, word 0x10 sent as 0x11 and word 0x80 sent as 0x00 -> err_count=2, reads return 00,02,10; pass=0.
3. Sync robustness: send 00,B8,B8,8B then data -> lock after the second B8; a stray B8,55 returns to SYNC_A with no false start.
4. Mode 2, PATTERN_LFSR_EN defined, send 256 LFSR words from seed 01 with taps B8 -> pass=1. Repeat with the macro undefined and an incrementing stream -> pass=1.
5. CNT_W=4, mode 0, send all-zero data -> err_count saturates at 15 and does not wrap.
6. Assert reset for 1 cycle at word 100 -> all outputs return to their reset values; a fresh full run afterwards passes.

Source files
------------

// File: rtl/bus_test_pkg.sv
// Shared constants for the RPi parallel-bus test blocks: FSM states, pattern modes
// and report word indices.
package bus_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC_A = 3'd1,
        ST_SYNC_B = 3'd2,
        ST_RECV   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_DEC   = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    localparam logic [1:0] RPT_PASS  = 2'd0;
    localparam logic [1:0] RPT_ERR   = 2'd1;
    localparam logic [1:0] RPT_FIRST = 2'd2;

endpackage

// File: rtl/bus_sync_edge.sv
// Brings the asynchronous RPi bus strobe, direction and data into the clk_100mhz
// domain and produces single-cycle rise/fall pulses for the strobe.
module bus_sync_edge #(
    parameter int DATA_W = 8
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    input  logic              bus_clk,
    input  logic              bus_rnw,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              rnw_sync,
    output logic [DATA_W-1:0] data_sync,
    output logic              clk_rise,
    output logic              clk_fall
);

    // [0] metastable stage, [1] synchronised, [2] previous synchronised value
    logic [2:0]        clk_sh_q;
    logic [1:0]        rnw_sh_q;
    logic [DATA_W-1:0] data_meta_q;
    logic [DATA_W-1:0] data_sync_q;

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            clk_sh_q    <= '0;
            rnw_sh_q    <= '0;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            clk_sh_q    <= {clk_sh_q[1:0], bus_clk};
            rnw_sh_q    <= {rnw_sh_q[0], bus_rnw};
            data_meta_q <= bus_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign rnw_sync  = rnw_sh_q[1];
    assign data_sync = data_sync_q;
    assign clk_rise  = clk_sh_q[1] & ~clk_sh_q[2];
    assign clk_fall  = ~clk_sh_q[1] & clk_sh_q[2];

endmodule

// File: rtl/bus_pattern_checker.sv
// Receive-side pattern checker for the RPi parallel bus with a 3-word status report.
// Define PATTERN_LFSR_EN to build the Galois LFSR pattern for mode 2 (otherwise mode 2 increments).
module bus_pattern_checker
    import bus_test_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                NUM_WORDS = 256,
    parameter logic [DATA_W-1:0] SYNC0     = DATA_W'(8'hB8),
    parameter logic [DATA_W-1:0] SYNC1     = DATA_W'(8'h8B),
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8),
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(8'h01),
    parameter int                CNT_W     = 16
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    input  logic              bus_clk,
    input  logic              bus_rnw,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_data_oe,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              pass,
    output logic              done,
    output logic [CNT_W-1:0]  err_count
);

    // The word counter must reach NUM_WORDS-1 even when the error counter is narrow.
    localparam int              IDX_W    = (CNT_W > 16) ? CNT_W : 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic              rnw_s;
    logic [DATA_W-1:0] data_s;
    logic              clk_rise;
    logic              clk_fall;

    bus_sync_edge #(.DATA_W(DATA_W)) u_sync (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .bus_clk     (bus_clk),
        .bus_rnw     (bus_rnw),
        .bus_data_in (bus_data_in),
        .rnw_sync    (rnw_s),
        .data_sync   (data_s),
        .clk_rise    (clk_rise),
        .clk_fall    (clk_fall)
    );

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [1:0]        rpt_q;
    logic [DATA_W-1:0] ref_q, ref_d, ref_init;
    logic [DATA_W-1:0] dout_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  first_q, first_d;
    logic              busy_q, pass_q, done_q, oe_q;
    logic              miss;

    function automatic logic [DATA_W-1:0] status_word(input logic [1:0] sel,
                                                      input logic [CNT_W-1:0] err,
                                                      input logic [CNT_W-1:0] first);
        logic [31:0] err_w;
        logic [31:0] first_w;
        err_w   = 32'(err);
        first_w = 32'(first);
        case (sel)
            RPT_PASS: return DATA_W'(err == '0);
            RPT_ERR:  return err_w[DATA_W-1:0];
            default:  return first_w[DATA_W-1:0];
        endcase
    endfunction

    always_comb begin
        // A strobe seen while the master is reading still consumes a data slot, as an error.
        miss    = rnw_s || (data_s != ref_q);
        err_d   = err_q;
        first_d = first_q;
        if (miss) begin
            if (err_q != CNT_MAX) err_d = err_q + 1'b1;
            if (err_q == '0)      first_d = idx_q[CNT_W-1:0];
        end

        case (mode_q)
            MODE_DEC:   ref_d = ref_q - 1'b1;
            MODE_CONST: ref_d = ref_q;
`ifdef PATTERN_LFSR_EN
            MODE_LFSR:  ref_d = (ref_q >> 1) ^ (ref_q[0] ? LFSR_TAPS : '0);
`endif
            default:    ref_d = ref_q + 1'b1;
        endcase

        case (mode)
            MODE_DEC:   ref_init = '1;
            MODE_CONST: ref_init = SYNC1;
`ifdef PATTERN_LFSR_EN
            MODE_LFSR:  ref_init = LFSR_SEED;
`endif
            default:    ref_init = '0;
        endcase
    end

`ifndef PATTERN_LFSR_EN
    logic unused_lfsr_cfg;
    assign unused_lfsr_cfg = ^{LFSR_TAPS, LFSR_SEED};
`endif

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INC;
            rpt_q   <= RPT_PASS;
            ref_q   <= '0;
            dout_q  <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= '1;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            oe_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    err_q   <= '0;
                    idx_q   <= '0;
                    first_q <= '1;
                    dout_q  <= '0;
                    state_q <= ST_SYNC_A;
                end
                ST_SYNC_A: begin
                    if (clk_rise && data_s == SYNC0) state_q <= ST_SYNC_B;
                end
                ST_SYNC_B: begin
                    if (clk_rise) begin
                        if (data_s == SYNC1) begin
                            mode_q  <= mode;
                            ref_q   <= ref_init;
                            busy_q  <= 1'b1;
                            state_q <= ST_RECV;
                        end else if (data_s != SYNC0) begin
                            state_q <= ST_SYNC_A;
                        end
                    end
                end
                ST_RECV: begin
                    if (clk_rise) begin
                        err_q   <= err_d;
                        first_q <= first_d;
                        ref_q   <= ref_d;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            rpt_q   <= RPT_PASS;
                            dout_q  <= status_word(RPT_PASS, err_d, first_d);
                            state_q <= ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    oe_q <= rnw_s;
                    // The master latches a word while its strobe is high; the falling edge consumes it.
                    if (clk_fall && rnw_s) begin
                        if (rpt_q == RPT_FIRST) begin
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == '0);
                            busy_q  <= 1'b0;
                            dout_q  <= '0;
                            oe_q    <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            rpt_q  <= rpt_q + 2'd1;
                            dout_q <= status_word(rpt_q + 2'd1, err_q, first_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_data_out = dout_q;
    assign bus_data_oe  = oe_q;
    assign busy         = busy_q;
    assign pass         = pass_q;
    assign done         = done_q;
    assign err_count    = err_q;

endmodule
